// File: rtl/mem_stage.sv
// Memory-access pipeline stage: ALU passthrough, request/ack load/store with
// bounded wait, registered writeback bundle and the architectural flags register.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accepting bundles from execute; no access outstanding
// WAIT  | dmem_req held high, waiting for dmem_ack or timeout; stall=1
module mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_mem_read,
  input  logic                      in_mem_write,
  input  logic                      in_reg_write,
  input  logic                      in_fl_write_enable,
  input  logic [1:0]                in_alu_flags,
  input  logic [DATA_WIDTH-1:0]     in_alu_data,
  input  logic [DATA_WIDTH-1:0]     in_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] in_dest,
  output logic                      stall,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [DATA_WIDTH-1:0]     dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  input  logic                      dmem_ack,
  output logic                      wb_valid,
  output logic                      wb_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] wb_dest,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [1:0]                flags,
  output logic                      bus_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      req_q, req_d;
  logic                      we_q, we_d;
  logic [DATA_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      wb_valid_q, wb_valid_d;
  logic                      wb_rw_q, wb_rw_d;
  logic [REG_ADDR_WIDTH-1:0] wb_dest_q, wb_dest_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic [1:0]                flags_q, flags_d;
  logic                      bus_err_q, bus_err_d;
  logic [REG_ADDR_WIDTH-1:0] lat_dest_q, lat_dest_d;
  logic                      lat_rw_q, lat_rw_d;
  logic                      lat_load_q, lat_load_d;

  // Next-state, request and writeback decode; every target defaulted first
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    wb_rw_d    = 1'b0;
    wb_dest_d  = wb_dest_q;
    wb_data_d  = wb_data_q;
    flags_d    = flags_q;
    bus_err_d  = 1'b0;
    lat_dest_d = lat_dest_q;
    lat_rw_d   = lat_rw_q;
    lat_load_d = lat_load_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_fl_write_enable) begin
            flags_d = in_alu_flags;
          end
          if (in_mem_read || in_mem_write) begin
            // read wins when both op bits are set
            lat_dest_d = in_dest;
            lat_rw_d   = in_reg_write;
            lat_load_d = in_mem_read;
            req_d      = 1'b1;
            we_d       = in_mem_write & ~in_mem_read;
            addr_d     = in_alu_data;
            wdata_d    = in_store_data;
            cnt_d      = '0;
            state_d    = S_WAIT;
          end else begin
            wb_valid_d = 1'b1;
            wb_rw_d    = in_reg_write;
            wb_dest_d  = in_dest;
            wb_data_d  = in_alu_data;
          end
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          // ack beats timeout when both land in the same cycle
          req_d      = 1'b0;
          we_d       = 1'b0;
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          wb_dest_d  = lat_dest_q;
          if (lat_load_q) begin
            wb_rw_d   = lat_rw_q;
            wb_data_d = dmem_rdata;
          end else begin
            wb_rw_d   = 1'b0;
            wb_data_d = '0;
          end
        end else if (cnt_q == CNT_LAST) begin
          req_d      = 1'b0;
          we_d       = 1'b0;
          state_d    = S_IDLE;
          bus_err_d  = 1'b1;
          wb_valid_d = 1'b1;
          wb_rw_d    = 1'b0;
          wb_dest_d  = lat_dest_q;
          wb_data_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
      flags_q    <= 2'b00;
      bus_err_q  <= 1'b0;
      lat_dest_q <= '0;
      lat_rw_q   <= 1'b0;
      lat_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_dest_q  <= wb_dest_d;
      wb_data_q  <= wb_data_d;
      flags_q    <= flags_d;
      bus_err_q  <= bus_err_d;
      lat_dest_q <= lat_dest_d;
      lat_rw_q   <= lat_rw_d;
      lat_load_q <= lat_load_d;
    end
  end

  assign stall        = (state_q == S_WAIT);
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_rw_q;
  assign wb_dest      = wb_dest_q;
  assign wb_data      = wb_data_q;
  assign flags        = flags_q;
  assign bus_err      = bus_err_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the core_lapido pipeline, directly downstream of the execute stage. Takes the ALU result, store data, destination register and flag results from execute. Performs loads and stores over a request/acknowledge data-memory port with a bounded wait. Presents a registered writeback bundle and stalls upstream while an access is outstanding. Also owns the architectural 2-bit ALU flags register.

## Interface
- DATA_WIDTH, 32, width of GPR data, addresses, memory data
- REG_ADDR_WIDTH, 5, destination register address width
- TIMEOUT_CYCLES, 16, max cycles in WAIT before abort (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  execute bundle valid this cycle
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- in_reg_write  in  1  instruction writes a GPR
- in_fl_write_enable  in  1  update flags register
- in_alu_flags  in  2  flags from ALU
- in_alu_data  in  DATA_WIDTH  ALU result / effective address
- in_store_data  in  DATA_WIDTH  store data (rt)
- in_dest  in  REG_ADDR_WIDTH  destination (rt, rd or 15)
- stall  out  1  upstream must hold its bundle
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  DATA_WIDTH  memory address
- dmem_wdata  out  DATA_WIDTH  write data
- dmem_rdata  in  DATA_WIDTH  read data, valid with ack
- dmem_ack  in  1  access complete
- wb_valid  out  1  writeback bundle valid (one-cycle pulse)
- wb_reg_write  out  1  write wb_data to wb_dest
- wb_dest  out  REG_ADDR_WIDTH  destination
- wb_data  out  DATA_WIDTH  load data or ALU result
- flags  out  2  architectural flags register
- bus_err  out  1  one-cycle pulse on access timeout

## Operation
- FSM states: IDLE, WAIT.
- stall = (state == WAIT). It is decoded from the state only, with no combinational path from inputs.
- IDLE, in_valid=0: wb_valid=0 next cycle.
- IDLE, in_valid=1, no memory op:
  - Register wb_valid=1, wb_reg_write=in_reg_write, wb_dest=in_dest, wb_data=in_alu_data.
  - Stay in IDLE.
- IDLE, in_valid=1, in_mem_read or in_mem_write:
  - Latch dest, reg_write and op.
  - Drive dmem_req=1, dmem_addr=in_alu_data, dmem_wdata=in_store_data, dmem_we=in_mem_write & ~in_mem_read.
  - Clear the timeout counter and go to WAIT.
  - Both read and write set: treated as a load (read wins).
- WAIT: dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable; the counter increments each cycle.
  - dmem_ack=1: deassert dmem_req and go to IDLE. Register wb_valid=1, wb_dest=latched dest.
    - Load: wb_data=dmem_rdata, wb_reg_write=latched reg_write.
    - Store: wb_reg_write=0, wb_data=0.
  - No ack and counter == TIMEOUT_CYCLES-1: deassert dmem_req, go to IDLE, pulse bus_err. Emit wb_valid=1 with wb_reg_write=0.
  - Ack in the timeout cycle: ack wins, normal completion, no bus_err.
  - in_valid is ignored in WAIT. Upstream holds its bundle because stall=1.
- Flags register: on any accepted bundle (IDLE & in_valid) with in_fl_write_enable=1, flags ← in_alu_flags at that edge. Otherwise flags hold. Memory ops may update flags too.
- Reset (asynchronous assert, any state, including mid-access) forces:
  - state=IDLE, stall=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0;
  - wb_valid=0, wb_reg_write=0, wb_dest=0, wb_data=0;
  - flags=2'b00, bus_err=0, counter=0.
  - Any in-flight access is abandoned; a late dmem_ack after reset is ignored.

## Timing
- All outputs except stall are registered; stall is decoded from registered state.
- Non-memory: bundle sampled at edge N, wb_valid high in cycle N+1, throughput 1 per cycle.
- Memory: bundle sampled at edge N, dmem_req high from cycle N+1. Ack sampled at edge M (M ≥ N+1); wb_valid high cycle M+1.
  - Minimum load/store latency is 2 cycles (ack in first request cycle).
  - stall is high in cycles N+1..M, and the next bundle is accepted at edge M+1.
- Timeout: with no ack, dmem_req is high for exactly TIMEOUT_CYCLES cycles. bus_err and wb_valid are both high in the following cycle.
- dmem_ack while dmem_req=0 is ignored.

## Test plan
- Reset: rst=0 mid-WAIT with dmem_req=1 → all outputs zero immediately, no clock needed. Ack after release produces no wb_valid.
- ALU passthrough: back-to-back in_valid, in_alu_data=0x11 then 0x22, in_reg_write=1, in_dest=3 then 4 → wb_valid on consecutive cycles with (3,0x11), (4,0x22); stall never high.
- Load, ack after 3 cycles: addr 0x100, dmem_rdata=0xDEADBEEF, dest 7 → dmem_req high 3 cycles, stall high 3 cycles, then wb_valid with wb_data=0xDEADBEEF, wb_dest=7, wb_reg_write=1.
- Store, ack same cycle: addr 0x40, data 0x5A5A → dmem_we=1, dmem_wdata=0x5A5A for 1 cycle; wb_valid next cycle with wb_reg_write=0.
- Timeout, TIMEOUT_CYCLES=16, no ack → dmem_req high exactly 16 cycles, then bus_err=1 and wb_valid=1 with wb_reg_write=0. Repeat with ack in cycle 16 → no bus_err, normal load data.
- Flags: in_fl_write_enable=1, in_alu_flags=2'b10 → flags=2'b10 next cycle. Bundle with enable=0 and flags 2'b01 → flags stay 2'b10.
